gate_test_seq: RTL

GATE_TEST_SEQ -- requirements
Module: gate_test_seq

---
 rtl/gate_test_seq_if.sv | 25 ++
 rtl/gate_test_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/gate_test_seq_if.sv
// Bundle of the run-control and gate-under-test signals for gate_test_seq.
// The slave modport faces the sequencer; master faces the environment driving it.
interface gate_test_seq_if;
  logic       start;
  logic       abort;
  logic [3:0] tt_exp;
  logic       dut_a;
  logic       dut_b;
  logic       dut_y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_mask;

  modport slave (
    input  start, abort, tt_exp, dut_y,
    output dut_a, dut_b, busy, done, pass, err_cnt, fail_mask
  );

  modport master (
    output start, abort, tt_exp, dut_y,
    input  dut_a, dut_b, busy, done, pass, err_cnt, fail_mask
  );
endinterface

// File: rtl/gate_test_seq.sv
// Two-input gate tester: walks vectors 00..11 onto the gate, holds each for
// SETTLE cycles, scores dut_y against a latched truth table and reports the result.
module gate_test_seq #(
  parameter int unsigned SETTLE = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  gate_test_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    DONE
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] tt_q, tt_d;
  logic [2:0] err_q, err_d;
  logic [3:0] mask_q, mask_d;
  logic       pass_q, pass_d;
  logic [1:0] drv_q, drv_d;
  logic       last_settle;
  logic       mismatch;

  assign last_settle = (cnt_q == LAST_CNT);
  assign mismatch    = (bus.dut_y != tt_q[vec_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = APPLY;
      APPLY: begin
        if (bus.abort)                          state_d = IDLE;
        else if (last_settle && vec_q == 2'd3)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state_q == APPLY);
    bus.done  = (state_q == DONE);
    bus.dut_a = drv_q[1];
    bus.dut_b = drv_q[0];
  end

  // Abort wins over scoring: the vector in flight is dropped unscored.
  always_comb begin
    vec_d  = vec_q;
    cnt_d  = cnt_q;
    tt_d   = tt_q;
    err_d  = err_q;
    mask_d = mask_q;
    pass_d = pass_q;
    drv_d  = drv_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          tt_d   = bus.tt_exp;
          err_d  = '0;
          mask_d = '0;
          pass_d = 1'b0;
          vec_d  = '0;
          cnt_d  = '0;
          drv_d  = '0;
        end
      end
      APPLY: begin
        if (bus.abort) begin
          vec_d = '0;
          cnt_d = '0;
          drv_d = '0;
        end else if (last_settle) begin
          if (mismatch) begin
            err_d         = (err_q == 3'd4) ? err_q : err_q + 3'd1;
            mask_d[vec_q] = 1'b1;
          end
          cnt_d = '0;
          if (vec_q == 2'd3) begin
            vec_d  = '0;
            drv_d  = '0;
            pass_d = (err_d == 3'd0);
          end else begin
            vec_d = vec_q + 2'd1;
            drv_d = vec_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        drv_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q  <= '0;
      cnt_q  <= '0;
      tt_q   <= '0;
      err_q  <= '0;
      mask_q <= '0;
      pass_q <= 1'b0;
      drv_q  <= '0;
    end else begin
      vec_q  <= vec_d;
      cnt_q  <= cnt_d;
      tt_q   <= tt_d;
      err_q  <= err_d;
      mask_q <= mask_d;
      pass_q <= pass_d;
      drv_q  <= drv_d;
    end
  end

  assign bus.pass      = pass_q;
  assign bus.err_cnt   = err_q;
  assign bus.fail_mask = mask_q;

endmodule
